// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the CPU it feeds:
// loader state encodings, the default frame header byte, CPU opcodes and
// the running-checksum helper.
package imem_loader_pkg;

  // Default start-of-frame byte on the host link.
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Loader frame-parser states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    CSUM  = 3'd4,
    START = 3'd5,
    ERR   = 3'd6
  } loader_state_e;

  // CPU opcodes carried in bits [15:12] of each instruction word.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LOAD = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_JMP  = 4'h5,
    OP_BEQ  = 4'h6,
    OP_HALT = 4'hF
  } cpu_opcode_e;

  // Modulo-256 accumulation used by the frame checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/imem_loader_byte_timer.sv
// Inter-byte idle counter. Counts cycles while run is high, saturating at
// TIMEOUT; clear returns it to zero and wins over run.
module byte_timer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [15:0] count_r;

  // Idle-cycle counter: cleared on demand, otherwise counts up to TIMEOUT and holds.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= 16'd0;
    end else if (run && (count_r != TIMEOUT)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == TIMEOUT);

endmodule

// File: rtl/imem_loader.sv
// Host-link boot loader: parses HEADER, N, 2N data bytes, CSUM frames,
// writes 16-bit words into instruction memory and starts the CPU once the
// checksum matches. Every output is driven straight from a register.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0]  HEADER  = HEADER_DEFAULT,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic        busy,
  output logic        err
);

  loader_state_e state_r, state_nx_s;
  logic [7:0]  len_r, len_nx_s;
  logic [7:0]  idx_r, idx_nx_s;
  logic [7:0]  sum_r, sum_nx_s;
  logic [7:0]  hi_r, hi_nx_s;
  logic        rx_ready_r, rx_ready_nx_s;
  logic        imem_we_r, imem_we_nx_s;
  logic [7:0]  imem_addr_r, imem_addr_nx_s;
  logic [15:0] imem_wdata_r, imem_wdata_nx_s;
  logic        cpu_enable_r, cpu_enable_nx_s;
  logic        cpu_start_r, cpu_start_nx_s;
  logic        busy_r, busy_nx_s;
  logic        err_r, err_nx_s;

  logic        acc_s;
  logic        in_frame_s;
  logic        expired_s;
  logic        timer_clear_s;
  logic [7:0]  last_idx_s;

  assign acc_s         = rx_valid && rx_ready_r;
  assign in_frame_s    = (state_r == LEN) || (state_r == HI) ||
                         (state_r == LO)  || (state_r == CSUM);
  // The timer only runs between bytes of a frame; any accepted byte restarts it.
  assign timer_clear_s = reset || acc_s || !in_frame_s;
  // N = 0 gives last_idx = 255, i.e. a full 256-word load.
  assign last_idx_s    = len_r - 8'd1;

  byte_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_byte_timer (
    .clk     (clk),
    .clear   (timer_clear_s),
    .run     (in_frame_s),
    .expired (expired_s)
  );

  // Next-state and next-output decode for the frame parser.
  always_comb begin
    state_nx_s      = state_r;
    len_nx_s        = len_r;
    idx_nx_s        = idx_r;
    sum_nx_s        = sum_r;
    hi_nx_s         = hi_r;
    imem_we_nx_s    = 1'b0;
    imem_addr_nx_s  = imem_addr_r;
    imem_wdata_nx_s = imem_wdata_r;
    cpu_enable_nx_s = cpu_enable_r;
    err_nx_s        = err_r;

    if (in_frame_s && expired_s) begin
      // A stalled host abandons the frame; the pending word is never written.
      state_nx_s      = ERR;
      err_nx_s        = 1'b1;
      cpu_enable_nx_s = 1'b0;
    end else begin
      case (state_r)
        IDLE, ERR: begin
          if (acc_s && (rx_data == HEADER)) begin
            state_nx_s      = LEN;
            err_nx_s        = 1'b0;
            cpu_enable_nx_s = 1'b0;
          end else begin
            state_nx_s = state_r;
          end
        end
        LEN: begin
          if (acc_s) begin
            len_nx_s   = rx_data;
            idx_nx_s   = 8'd0;
            sum_nx_s   = rx_data;
            state_nx_s = HI;
          end else begin
            state_nx_s = LEN;
          end
        end
        HI: begin
          if (acc_s) begin
            hi_nx_s    = rx_data;
            sum_nx_s   = csum_add(sum_r, rx_data);
            state_nx_s = LO;
          end else begin
            state_nx_s = HI;
          end
        end
        LO: begin
          if (acc_s) begin
            imem_we_nx_s    = 1'b1;
            imem_addr_nx_s  = idx_r;
            imem_wdata_nx_s = {hi_r, rx_data};
            idx_nx_s        = idx_r + 8'd1;
            sum_nx_s        = csum_add(sum_r, rx_data);
            if (idx_r == last_idx_s) begin
              state_nx_s = CSUM;
            end else begin
              state_nx_s = HI;
            end
          end else begin
            state_nx_s = LO;
          end
        end
        CSUM: begin
          if (acc_s) begin
            if (rx_data == sum_r) begin
              state_nx_s      = START;
              cpu_enable_nx_s = 1'b1;
            end else begin
              state_nx_s      = ERR;
              err_nx_s        = 1'b1;
              cpu_enable_nx_s = 1'b0;
            end
          end else begin
            state_nx_s = CSUM;
          end
        end
        START: begin
          state_nx_s      = IDLE;
          cpu_enable_nx_s = 1'b1;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end

    // Status outputs are registered copies of what the next state implies.
    cpu_start_nx_s = (state_nx_s == START);
    rx_ready_nx_s  = (state_nx_s != START);
    busy_nx_s      = (state_nx_s == LEN) || (state_nx_s == HI) || (state_nx_s == LO) ||
                     (state_nx_s == CSUM) || (state_nx_s == START);
  end

  // State and output registers; reset wins over any byte accepted on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      len_r        <= 8'd0;
      idx_r        <= 8'd0;
      sum_r        <= 8'd0;
      hi_r         <= 8'd0;
      rx_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= 8'd0;
      imem_wdata_r <= 16'd0;
      cpu_enable_r <= 1'b0;
      cpu_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      len_r        <= len_nx_s;
      idx_r        <= idx_nx_s;
      sum_r        <= sum_nx_s;
      hi_r         <= hi_nx_s;
      rx_ready_r   <= rx_ready_nx_s;
      imem_we_r    <= imem_we_nx_s;
      imem_addr_r  <= imem_addr_nx_s;
      imem_wdata_r <= imem_wdata_nx_s;
      cpu_enable_r <= cpu_enable_nx_s;
      cpu_start_r  <= cpu_start_nx_s;
      busy_r       <= busy_nx_s;
      err_r        <= err_nx_s;
    end
  end

  assign rx_ready   = rx_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_enable = cpu_enable_r;
  assign cpu_start  = cpu_start_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes and
// start pulses into a queue; a monitor pops and compares on every imem_we
// or cpu_start the DUT presents.
module tb_imem_loader;

  localparam logic [15:0] TB_TIMEOUT = 16'd40;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_enable;
  logic        cpu_start;
  logic        busy;
  logic        err;

  imem_loader #(
    .HEADER  (8'hA5),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    bit          is_start;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         total_tries = 0;

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_write(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.is_start = 1'b0;
    e.addr     = a;
    e.data     = d;
    exp_q.push_back(e);
  endtask

  task automatic push_start();
    exp_t e;
    e.is_start = 1'b1;
    e.addr     = 8'd0;
    e.data     = 16'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every write strobe and start pulse against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (imem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.is_start || imem_addr !== e.addr || imem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h, expected start=%0b addr %0h data %0h",
                   imem_addr, imem_wdata, e.is_start, e.addr, e.data);
        end
      end
    end
    if (cpu_start) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start: got cpu_start=1, expected 0");
      end else begin
        e = exp_q.pop_front();
        if (!e.is_start || cpu_enable !== 1'b1) begin
          n_fail++;
          $display("FAIL start: got start with cpu_enable=%0b, expected start=%0b enable=1",
                   cpu_enable, e.is_start);
        end
      end
    end
  end

  // Drive one byte and hold it until the DUT accepts it (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   tries;
    rdy   = 1'b0;
    tries = 0;
    while (!rdy && tries < 50) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      rdy      = rx_ready;
      @(posedge clk);
      tries++;
    end
    total_tries += tries;
    if (!rdy) begin
      chk("send_accept", 32'(rdy), 32'd1);
    end
  endtask

  task automatic send_all();
    foreach (tx_q[i]) send_byte(tx_q[i]);
  endtask

  task automatic idle_bus(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Wait for the scoreboard to empty, then let the FSM settle.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame_a(input logic [7:0] cs, input bit good);
    tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, cs};
    push_write(8'd0, 16'h1122);
    push_write(8'd1, 16'h3344);
    if (good) push_start();
    send_all();
    idle_bus(1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    chk({tag, "_cpu_enable"}, 32'(cpu_enable), 32'd0);
    chk({tag, "_cpu_start"},  32'(cpu_start),  32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  // Global time bound.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] s;
    logic [7:0] hb;
    logic [7:0] lb;
    int         t0;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Good frame: two writes, one start, CPU left enabled.
    frame_a(8'hAC, 1'b1);
    wait_drain("frameA_drain");
    chk("frameA_err",    32'(err),        32'd0);
    chk("frameA_enable", 32'(cpu_enable), 32'd1);
    chk("frameA_busy",   32'(busy),       32'd0);

    // Bad checksum: writes still happen, no start, error latched.
    frame_a(8'hAD, 1'b0);
    wait_drain("badcs_drain");
    chk("badcs_err",    32'(err),        32'd1);
    chk("badcs_enable", 32'(cpu_enable), 32'd0);

    // Recovery: header alone clears err, full frame starts the CPU.
    push_write(8'd0, 16'h1122);
    push_write(8'd1, 16'h3344);
    push_start();
    send_byte(8'hA5);
    #1;
    chk("recover_hdr_err",  32'(err),  32'd0);
    chk("recover_hdr_busy", 32'(busy), 32'd1);
    tx_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
    send_all();
    idle_bus(1);
    wait_drain("recover_drain");
    chk("recover_err",    32'(err),        32'd0);
    chk("recover_enable", 32'(cpu_enable), 32'd1);

    // Header value inside the payload is plain data.
    tx_q = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h4B};
    push_write(8'd0, 16'hA5A5);
    push_start();
    send_all();
    idle_bus(1);
    wait_drain("hdrdata_drain");
    chk("hdrdata_err", 32'(err), 32'd0);

    // N = 0: full 256-word load with wrapping index.
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h00);
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      hb = 8'(i);
      lb = 8'(i) + 8'h3C;
      tx_q.push_back(hb);
      tx_q.push_back(lb);
      s = s + hb + lb;
      push_write(8'(i), {hb, lb});
    end
    tx_q.push_back(s);
    push_start();
    send_all();
    idle_bus(1);
    wait_drain("n256_drain");
    chk("n256_err",    32'(err),        32'd0);
    chk("n256_enable", 32'(cpu_enable), 32'd1);

    // Stall after a high byte: no write for that word, error, needs new header.
    tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    push_write(8'd0, 16'h1122);
    send_all();
    idle_bus(int'(TB_TIMEOUT) + 6);
    #1;
    chk("timeout_err",    32'(err),        32'd1);
    chk("timeout_busy",   32'(busy),       32'd0);
    chk("timeout_enable", 32'(cpu_enable), 32'd0);
    send_byte(8'h44);
    idle_bus(2);
    #1;
    chk("timeout_stray_busy", 32'(busy), 32'd0);
    wait_drain("timeout_drain");
    frame_a(8'hAC, 1'b1);
    wait_drain("timeout_recover_drain");
    chk("timeout_recover_err", 32'(err), 32'd0);

    // Garbage with rx_valid held high: one byte per cycle, no writes while idle.
    t0 = total_tries;
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    #1;
    chk("garbage_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    chk("garbage_cycles", 32'(total_tries - t0), 32'd6);
    push_write(8'd0, 16'h1122);
    push_write(8'd1, 16'h3344);
    push_start();
    tx_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
    send_all();
    idle_bus(1);
    wait_drain("garbage_drain");
    chk("garbage_enable", 32'(cpu_enable), 32'd1);

    // Reset while in LO with a byte offered on the same edge.
    tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    push_write(8'd0, 16'h1122);
    send_all();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    @(posedge clk);
    #1;
    chk_reset_values("lo_reset");
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    wait_drain("lo_reset_drain");
    send_byte(8'h44);
    #1;
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    #1;
    chk("post_reset_hdr_busy", 32'(busy), 32'd1);
    push_write(8'd0, 16'h1122);
    push_write(8'd1, 16'h3344);
    push_start();
    tx_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
    send_all();
    idle_bus(1);
    wait_drain("post_reset_drain");
    chk("post_reset_enable", 32'(cpu_enable), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
